tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer that sits directly downstream of the 2:1 gate-level mux and its wider variants. The mux time-shares one data path between channels. This block consumes that serial slot stream and routes each slot into a per-channel holding register, raising a per-channel valid pulse. It tracks frame alignment with a slot counter, checks frame length, and flags malformed frames.

## Interface
- `NUM_CH`, default 2: channels per frame, minimum 2.
- `DATA_W`, default 1: width of one slot word, minimum 1.
- `clk`, input, 1: single clock; all logic runs on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset. Deassertion is synchronous to `clk` upstream.
- `din`, input, `DATA_W`: slot word from the mux output.
- `din_valid`, input, 1: `din` holds a slot this cycle.
- `frame_start`, input, 1: marks the current valid slot as slot 0. It is ignored when `din_valid` is 0.
- `din_par`, input, 1: even-parity bit for `din`. Present only with `TDM_DEMUX_PARITY_EN`.
- `ch_data`, output, `NUM_CH*DATA_W`: channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `ch_valid`, output, `NUM_CH`: one-cycle pulse on bit k when channel k is written.
- `frame_done`, output, 1: one-cycle pulse when slot `NUM_CH-1` of an aligned frame is written.
- `frame_err`, output, 1: one-cycle pulse on a short or long frame.
- `par_err`, output, 1: one-cycle pulse on a parity mismatch. Present only with `TDM_DEMUX_PARITY_EN`.

## Operation
- **Reset values:** all outputs are 0, `ch_data` is all zeros, the FSM is in IDLE and the slot counter is 0.
- **FSM states:** IDLE (unaligned) and RUN (aligned, the counter gives the expected slot).
- **IDLE:**
  - `din_valid` with `frame_start`: write channel 0, set the counter to 1, go to RUN.
  - `din_valid` without `frame_start`: drop the word, no pulses, stay in IDLE.
- **RUN:**
  - `din_valid` without `frame_start` and counter c > 0: write channel c.
  - If c = `NUM_CH-1`, also pulse `frame_done`, set the counter to 0 and stay in RUN, expecting `frame_start` next.
  - Otherwise increment c.
- **RUN, `frame_start` with counter ≠ 0 (short frame):**
  - Pulse `frame_err`.
  - Treat the word as slot 0 of a new frame: write channel 0 and set the counter to 1.
  - Channels already written in the aborted frame keep their values.
- **RUN, `din_valid` without `frame_start` and counter = 0 (long frame):**
  - Pulse `frame_err`, drop the word, go to IDLE.
- **RUN, `frame_start` with counter = 0:** normal start of the next frame; write channel 0 and set the counter to 1.
- **Held values:** `ch_data` is held between writes; only the addressed slice changes.
- **Counter:** width is `$clog2(NUM_CH)`. It never exceeds `NUM_CH-1`, so no wrap to unused codes is reachable.
- **Reset mid-frame:** everything returns to reset values immediately, including `ch_data`. The next frame must begin with `frame_start`.

## Timing
- Registered outputs with 1-cycle latency: the slot accepted at edge n appears on `ch_data`/`ch_valid` after edge n, in the same cycle as `frame_done` and `frame_err`.
- Back-to-back slots at 1 word per clock with no bubbles. Gaps (`din_valid` = 0) are allowed anywhere and do not change state.
- There is no backpressure; the block always accepts.
- At most one `ch_valid` bit is high per cycle.
- `frame_err` and `ch_valid[0]` pulse together on a short frame.
- `frame_err` pulses alone on a long frame.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- **Defined:**
  - The `din_par` and `par_err` ports exist.
  - Parity is checked on every accepted word, including dropped ones.
  - On a mismatch, `par_err` pulses with the same 1-cycle latency. The word is still written and alignment is unaffected.
- **Undefined:** neither port exists, and there is no parity logic.

## Structure
- **Package `tdm_pkg`:**
  - state encoding constants `ST_IDLE` = 1'b0 and `ST_RUN` = 1'b1;
  - a slot-width function `slot_w(n)` = max(1, `$clog2(n)`).
  - The upstream mux-select sequencer reuses both.
- **Sub-module `tdm_slot_counter`:** counter with `load0`, `inc` and `wrap_at` (`NUM_CH-1`), plus `is_last` and `is_zero` flags.
- **Top level:** the FSM, write-enable decode and output registers.

## Test plan
1. Reset, `NUM_CH`=2, `DATA_W`=1: slots 1, 0 with `frame_start` on the first.
   - `ch_data`=2'b01, `ch_valid` 01 then 10, `frame_done` on the second.
2. `NUM_CH`=4, `DATA_W`=8: slots A1, B2, C3, D4 with gaps between them.
   - `ch_data`=32'hD4C3B2A1, single `frame_done`, no `frame_err`.
3. `NUM_CH`=4: `frame_start`+11, then 22, then `frame_start`+33.
   - `frame_err` with `ch_valid`=0001.
   - Channel 0 = 33, channel 1 = 22 retained.
4. After a complete frame, `din_valid`=1 without `frame_start`.
   - `frame_err` pulse, word dropped, IDLE.
   - The next non-start words are ignored until `frame_start`.
5. Assert `rst_n` low mid-frame after 2 slots.
   - Outputs go to 0 immediately.
   - The post-reset words without `frame_start` are dropped.
6. With `TDM_DEMUX_PARITY_EN`, `DATA_W`=8: `din`=8'h03 with `din_par`=1.
   - `par_err` pulses and the word is still written.
   - `din_par`=0 gives no `par_err`.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM slot path: state encoding and slot-index width.
// Also used by the upstream mux-select sequencer.
package tdm_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        TDM_IDLE = ST_IDLE,
        TDM_RUN  = ST_RUN
    } tdm_state_e;

    // Index width for n slots, never narrower than one bit.
    function automatic int slot_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Expected-slot counter: load0 marks slot 0 as taken (next expected is 1),
// inc advances and wraps to 0 after WRAP_AT.
module tdm_slot_counter #(
    parameter int CW      = 1,
    parameter int WRAP_AT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load0_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          is_last_o,
    output logic          is_zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          is_last_s;

    assign is_last_s = (cnt_q == CW'(WRAP_AT));
    assign is_last_o = is_last_s;
    assign is_zero_o = (cnt_q == '0);
    assign cnt_o     = cnt_q;

    // Next-count selection; load0 wins over inc.
    always_comb begin
        cnt_d = cnt_q;
        if (load0_i) begin
            cnt_d = CW'(1);
        end else if (inc_i) begin
            if (is_last_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM slot demultiplexer with frame alignment and frame-length checking.
// Optional even-parity check on din is enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_start,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                     din_par,
    output logic                     par_err,
`endif
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam int CW = slot_w(NUM_CH);

    tdm_state_e                state_q, state_d;
    logic [NUM_CH*DATA_W-1:0]  ch_data_q, ch_data_d;
    logic [NUM_CH-1:0]         ch_valid_q, ch_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      frame_err_q, frame_err_d;

    logic                      wr_en_s;
    logic [CW-1:0]             wr_idx_s;
    logic                      load0_s;
    logic                      inc_s;
    logic [CW-1:0]             cnt_s;
    logic                      is_last_s;
    logic                      is_zero_s;

    tdm_slot_counter #(
        .CW      (CW),
        .WRAP_AT (NUM_CH - 1)
    ) u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load0_i   (load0_s),
        .inc_i     (inc_s),
        .cnt_o     (cnt_s),
        .is_last_o (is_last_s),
        .is_zero_o (is_zero_s)
    );

    // Alignment FSM: decides which slot (if any) is written and which flags pulse.
    always_comb begin
        state_d      = state_q;
        wr_en_s      = 1'b0;
        wr_idx_s     = '0;
        load0_s      = 1'b0;
        inc_s        = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        if (din_valid) begin
            case (state_q)
                TDM_IDLE: begin
                    if (frame_start) begin
                        wr_en_s = 1'b1;
                        load0_s = 1'b1;
                        state_d = TDM_RUN;
                    end else begin
                        state_d = TDM_IDLE;
                    end
                end
                TDM_RUN: begin
                    if (frame_start) begin
                        // A start with the counter mid-frame aborts a short frame.
                        frame_err_d = !is_zero_s;
                        wr_en_s     = 1'b1;
                        load0_s     = 1'b1;
                    end else if (is_zero_s) begin
                        frame_err_d = 1'b1;
                        state_d     = TDM_IDLE;
                    end else begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = cnt_s;
                        inc_s        = 1'b1;
                        frame_done_d = is_last_s;
                    end
                end
                default: begin
                    state_d = TDM_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Write-enable decode into the addressed channel slice only.
    always_comb begin
        ch_data_d  = ch_data_q;
        ch_valid_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en_s && (int'(wr_idx_s) == k)) begin
                ch_data_d[k*DATA_W +: DATA_W] = din;
                ch_valid_d[k]                 = 1'b1;
            end else begin
                ch_data_d[k*DATA_W +: DATA_W] = ch_data_q[k*DATA_W +: DATA_W];
                ch_valid_d[k]                 = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TDM_IDLE;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_err_q;
    logic par_err_d;

    function automatic logic par_bad(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    // Parity is checked on every accepted word, dropped or written.
    always_comb begin
        if (din_valid) begin
            par_err_d = par_bad(din, din_par);
        end else begin
            par_err_d = 1'b0;
        end
    end

    // Parity flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a 4x8 and a 2x1 instance share one stimulus
// stream; a behavioural frame model predicts each cycle's outputs.
module tb_tdm_demux;

    typedef struct packed {
        logic [31:0] a_data;
        logic [3:0]  a_vld;
        logic        a_fd;
        logic        a_fe;
        logic        a_pe;
        logic [1:0]  b_data;
        logic [1:0]  b_vld;
        logic        b_fd;
        logic        b_fe;
        logic        b_pe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid;
    logic        frame_start;
    logic [7:0]  din;
    logic        din_par;
    logic [31:0] a_data;
    logic [3:0]  a_vld;
    logic        a_fd, a_fe;
    logic [1:0]  b_data, b_vld;
    logic        b_fd, b_fe;
`ifdef TDM_DEMUX_PARITY_EN
    logic        a_pe, b_pe;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];

    int          m_run [2];
    int          m_cnt [2];
    logic [7:0]  m_dat [2][4];

    always #5 clk = ~clk;

    tdm_demux #(.NUM_CH(4), .DATA_W(8)) u_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
`ifdef TDM_DEMUX_PARITY_EN
        .din_par     (din_par),
        .par_err     (a_pe),
`endif
        .ch_data     (a_data),
        .ch_valid    (a_vld),
        .frame_done  (a_fd),
        .frame_err   (a_fe)
    );

    tdm_demux #(.NUM_CH(2), .DATA_W(1)) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din[0:0]),
        .din_valid   (din_valid),
        .frame_start (frame_start),
`ifdef TDM_DEMUX_PARITY_EN
        .din_par     (din_par),
        .par_err     (b_pe),
`endif
        .ch_data     (b_data),
        .ch_valid    (b_vld),
        .frame_done  (b_fd),
        .frame_err   (b_fe)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0;
            m_cnt[i] = 0;
            for (int k = 0; k < 4; k++) m_dat[i][k] = 8'h00;
        end
    endtask

    // Reference frame model for instance i with nch channels.
    task automatic model_step(input int i, input int nch, input logic v, input logic fs,
                              input logic [7:0] w, output logic [3:0] vld,
                              output logic fd, output logic fe);
        vld = 4'b0000;
        fd  = 1'b0;
        fe  = 1'b0;
        if (v) begin
            if (m_run[i] == 0) begin
                if (fs) begin
                    m_dat[i][0] = w; vld[0] = 1'b1; m_cnt[i] = 1; m_run[i] = 1;
                end
            end else if (fs) begin
                if (m_cnt[i] != 0) fe = 1'b1;
                m_dat[i][0] = w; vld[0] = 1'b1; m_cnt[i] = 1;
            end else if (m_cnt[i] == 0) begin
                fe = 1'b1; m_run[i] = 0;
            end else begin
                m_dat[i][m_cnt[i]] = w;
                vld[m_cnt[i]] = 1'b1;
                if (m_cnt[i] == nch - 1) begin
                    fd = 1'b1; m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got no entry expected one");
            return;
        end
        e = sb.pop_front();
        check_eq("a_data", a_data, e.a_data);
        check_eq("a_vld",  {28'd0, a_vld}, {28'd0, e.a_vld});
        check_eq("a_fd",   {31'd0, a_fd}, {31'd0, e.a_fd});
        check_eq("a_fe",   {31'd0, a_fe}, {31'd0, e.a_fe});
        check_eq("b_data", {30'd0, b_data}, {30'd0, e.b_data});
        check_eq("b_vld",  {30'd0, b_vld}, {30'd0, e.b_vld});
        check_eq("b_fd",   {31'd0, b_fd}, {31'd0, e.b_fd});
        check_eq("b_fe",   {31'd0, b_fe}, {31'd0, e.b_fe});
`ifdef TDM_DEMUX_PARITY_EN
        check_eq("a_pe",   {31'd0, a_pe}, {31'd0, e.a_pe});
        check_eq("b_pe",   {31'd0, b_pe}, {31'd0, e.b_pe});
`endif
    endtask

    // Drive one cycle of stimulus, push the prediction, compare after the edge.
    task automatic step(input logic v, input logic fs, input logic [7:0] d, input logic p);
        exp_t       e;
        logic [3:0] bv;
        din_valid   = v;
        frame_start = fs;
        din         = d;
        din_par     = p;
        e = '0;
        model_step(0, 4, v, fs, d, e.a_vld, e.a_fd, e.a_fe);
        model_step(1, 2, v, fs, {7'd0, d[0]}, bv, e.b_fd, e.b_fe);
        e.b_vld  = bv[1:0];
        e.a_data = {m_dat[0][3], m_dat[0][2], m_dat[0][1], m_dat[0][0]};
        e.b_data = {m_dat[1][1][0], m_dat[1][0][0]};
        e.a_pe   = v & ((^d) ^ p);
        e.b_pe   = v & (d[0] ^ p);
        sb.push_back(e);
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        din         = 8'h00;
        din_par     = 1'b0;
        model_reset();
        #1;
        check_eq("rst_a_data", a_data, 32'd0);
        check_eq("rst_a_flags", {26'd0, a_vld, a_fd, a_fe}, 32'd0);
        check_eq("rst_b_out", {26'd0, b_data, b_vld, b_fd, b_fe}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        #2;
        do_reset();

        // 2x1 frame: slots 1, 0.
        step(1'b1, 1'b1, 8'h01, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("t1_b_data", {30'd0, b_data}, 32'd1);
        check_eq("t1_b_fd", {31'd0, b_fd}, 32'd1);

        // 4x8 frame with gaps.
        do_reset();
        step(1'b1, 1'b1, 8'hA1, 1'b0);
        step(1'b0, 1'b0, 8'h55, 1'b0);
        step(1'b1, 1'b0, 8'hB2, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'hC3, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'hD4, 1'b0);
        check_eq("t2_a_data", a_data, 32'hD4C3B2A1);
        check_eq("t2_a_fd", {31'd0, a_fd}, 32'd1);

        // Short frame.
        do_reset();
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0);
        check_eq("t3_a_fe_vld", {27'd0, a_fe, a_vld}, 32'h11);
        check_eq("t3_a_data", {16'd0, a_data[15:0]}, 32'h2233);

        // Long frame after a complete one, then resync.
        do_reset();
        step(1'b1, 1'b1, 8'h10, 1'b1);
        step(1'b1, 1'b0, 8'h20, 1'b1);
        step(1'b1, 1'b0, 8'h30, 1'b0);
        step(1'b1, 1'b0, 8'h40, 1'b1);
        step(1'b1, 1'b0, 8'h99, 1'b0);
        check_eq("t4_a_fe", {27'd0, a_fe, a_vld}, 32'h10);
        step(1'b1, 1'b0, 8'h98, 1'b1);
        step(1'b1, 1'b0, 8'h97, 1'b1);
        check_eq("t4_a_hold", a_data, 32'h40302010);
        step(1'b1, 1'b1, 8'h5A, 1'b0);

        // Reset mid-frame, then unaligned words are dropped.
        step(1'b1, 1'b0, 8'h6B, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 8'h7C, 1'b1);
        step(1'b1, 1'b0, 8'h8D, 1'b0);
        check_eq("t5_a_data", a_data, 32'd0);

        // Parity words; par_err is compared by the scoreboard when enabled.
        step(1'b1, 1'b1, 8'h03, 1'b1);
        step(1'b1, 1'b0, 8'h03, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        step(1'b1, 1'b0, 8'h03, 1'b1);
        check_eq("t6_a_pe", {31'd0, a_pe}, 32'd1);
        check_eq("t6_a_written", {24'd0, a_data[23:16]}, 32'h03);
`endif

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
